// File: rtl/id_pipe_pkg.sv
// Shared decode definitions for the ID stage: instruction marks, type codes,
// opcode/funct values, immediate extension modes and the decoder result payload.
package id_pipe_pkg;

  localparam int unsigned INST_W = 8;
  localparam int unsigned TYPE_W = 2;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned EXT_W  = 2;

  localparam logic [INST_W-1:0] INST_INVALID = 8'd0;
  localparam logic [INST_W-1:0] INST_ADD     = 8'd1;
  localparam logic [INST_W-1:0] INST_ADDU    = 8'd2;
  localparam logic [INST_W-1:0] INST_SUB     = 8'd3;
  localparam logic [INST_W-1:0] INST_SUBU    = 8'd4;
  localparam logic [INST_W-1:0] INST_AND     = 8'd5;
  localparam logic [INST_W-1:0] INST_OR      = 8'd6;
  localparam logic [INST_W-1:0] INST_XOR     = 8'd7;
  localparam logic [INST_W-1:0] INST_NOR     = 8'd8;
  localparam logic [INST_W-1:0] INST_SLT     = 8'd9;
  localparam logic [INST_W-1:0] INST_SLTU    = 8'd10;
  localparam logic [INST_W-1:0] INST_SLL     = 8'd11;
  localparam logic [INST_W-1:0] INST_SRL     = 8'd12;
  localparam logic [INST_W-1:0] INST_SRA     = 8'd13;
  localparam logic [INST_W-1:0] INST_JR      = 8'd14;
  localparam logic [INST_W-1:0] INST_ADDI    = 8'd15;
  localparam logic [INST_W-1:0] INST_ADDIU   = 8'd16;
  localparam logic [INST_W-1:0] INST_SLTI    = 8'd17;
  localparam logic [INST_W-1:0] INST_SLTIU   = 8'd18;
  localparam logic [INST_W-1:0] INST_ANDI    = 8'd19;
  localparam logic [INST_W-1:0] INST_ORI     = 8'd20;
  localparam logic [INST_W-1:0] INST_XORI    = 8'd21;
  localparam logic [INST_W-1:0] INST_LUI     = 8'd22;
  localparam logic [INST_W-1:0] INST_BEQ     = 8'd23;
  localparam logic [INST_W-1:0] INST_BNE     = 8'd24;
  localparam logic [INST_W-1:0] INST_LW      = 8'd25;
  localparam logic [INST_W-1:0] INST_SW      = 8'd26;
  localparam logic [INST_W-1:0] INST_LB      = 8'd27;
  localparam logic [INST_W-1:0] INST_SB      = 8'd28;
  localparam logic [INST_W-1:0] INST_J       = 8'd29;
  localparam logic [INST_W-1:0] INST_JAL     = 8'd30;

  localparam logic [TYPE_W-1:0] INST_TYPE_INVALID = 2'd0;
  localparam logic [TYPE_W-1:0] INST_TYPE_R       = 2'd1;
  localparam logic [TYPE_W-1:0] INST_TYPE_I       = 2'd2;
  localparam logic [TYPE_W-1:0] INST_TYPE_J       = 2'd3;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [EXT_W-1:0] EXT_SIGN  = 2'd0;
  localparam logic [EXT_W-1:0] EXT_ZERO  = 2'd1;
  localparam logic [EXT_W-1:0] EXT_UPPER = 2'd2;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [TYPE_W-1:0] itype;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [15:0]       imm16;
    logic [EXT_W-1:0]  ext_mode;
    logic [REG_W-1:0]  shamt;
  } dec_t;

endpackage

// File: rtl/id_pipe_decode.sv
// Pure combinational R/I/J decoder; fields not used by the matched type are zero.
module id_decode
  import id_pipe_pkg::*;
(
  input  logic [31:0] inst_code,
  output dec_t        dec
);

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic              i_hit;
  logic              r_hit;
  logic              j_hit;
  logic              r_shift;
  logic [INST_W-1:0] i_inst;
  logic [INST_W-1:0] r_inst;
  logic [INST_W-1:0] j_inst;
  logic [EXT_W-1:0]  i_ext;

  assign opcode = inst_code[31:26];
  assign funct  = inst_code[5:0];

  always_comb begin : i_match
    i_hit  = 1'b1;
    i_inst = INST_INVALID;
    i_ext  = EXT_SIGN;
    case (opcode)
      OP_ADDI:  i_inst = INST_ADDI;
      OP_ADDIU: i_inst = INST_ADDIU;
      OP_SLTI:  i_inst = INST_SLTI;
      OP_SLTIU: i_inst = INST_SLTIU;
      OP_BEQ:   i_inst = INST_BEQ;
      OP_BNE:   i_inst = INST_BNE;
      OP_LW:    i_inst = INST_LW;
      OP_SW:    i_inst = INST_SW;
      OP_LB:    i_inst = INST_LB;
      OP_SB:    i_inst = INST_SB;
      OP_ANDI:  begin i_inst = INST_ANDI; i_ext = EXT_ZERO;  end
      OP_ORI:   begin i_inst = INST_ORI;  i_ext = EXT_ZERO;  end
      OP_XORI:  begin i_inst = INST_XORI; i_ext = EXT_ZERO;  end
      OP_LUI:   begin i_inst = INST_LUI;  i_ext = EXT_UPPER; end
      default:  i_hit = 1'b0;
    endcase
  end

  always_comb begin : r_match
    r_hit   = 1'b1;
    r_inst  = INST_INVALID;
    r_shift = 1'b0;
    case (funct)
      FN_SLL:  begin r_inst = INST_SLL; r_shift = 1'b1; end
      FN_SRL:  begin r_inst = INST_SRL; r_shift = 1'b1; end
      FN_SRA:  begin r_inst = INST_SRA; r_shift = 1'b1; end
      FN_JR:   r_inst = INST_JR;
      FN_ADD:  r_inst = INST_ADD;
      FN_ADDU: r_inst = INST_ADDU;
      FN_SUB:  r_inst = INST_SUB;
      FN_SUBU: r_inst = INST_SUBU;
      FN_AND:  r_inst = INST_AND;
      FN_OR:   r_inst = INST_OR;
      FN_XOR:  r_inst = INST_XOR;
      FN_NOR:  r_inst = INST_NOR;
      FN_SLT:  r_inst = INST_SLT;
      FN_SLTU: r_inst = INST_SLTU;
      default: r_hit = 1'b0;
    endcase
    if (opcode != OP_SPECIAL) r_hit = 1'b0;
  end

  always_comb begin : j_match
    j_hit  = (opcode == OP_J) || (opcode == OP_JAL);
    j_inst = (opcode == OP_JAL) ? INST_JAL : INST_J;
  end

  // Priority I, then R, then J; anything else stays all-zero (INVALID).
  always_comb begin : assemble
    dec = '0;
    if (i_hit) begin
      dec.inst     = i_inst;
      dec.itype    = INST_TYPE_I;
      dec.rs       = inst_code[25:21];
      dec.rt       = inst_code[20:16];
      dec.imm16    = inst_code[15:0];
      dec.ext_mode = i_ext;
    end else if (r_hit) begin
      dec.inst  = r_inst;
      dec.itype = INST_TYPE_R;
      dec.rs    = inst_code[25:21];
      dec.rt    = inst_code[20:16];
      dec.rd    = inst_code[15:11];
      dec.shamt = r_shift ? inst_code[10:6] : 5'd0;
    end else if (j_hit) begin
      dec.inst  = j_inst;
      dec.itype = INST_TYPE_J;
    end
  end

endmodule

// File: rtl/id_pipe.sv
// Registered, flow-controlled instruction-decode stage with a 2-entry skid
// buffer (main entry drives outputs, skid entry absorbs one stalled accept).
module id_pipe
  import id_pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter bit          SKID_EN  = 1'b1,
  parameter int unsigned LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [31:0]       in_inst_code,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [7:0]        out_inst,
  output logic [1:0]        out_type,
  output logic [4:0]        out_reg_s,
  output logic [4:0]        out_reg_t,
  output logic [4:0]        out_reg_d,
  output logic [DATA_W-1:0] out_imm,
  output logic [4:0]        out_shift,
  output logic [DATA_W-1:0] out_jump_target,
  output logic              out_exc_ri
);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic [TYPE_W-1:0] itype;
    logic [REG_W-1:0]  reg_s;
    logic [REG_W-1:0]  reg_t;
    logic [REG_W-1:0]  reg_d;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  shift;
    logic [DATA_W-1:0] jump_target;
    logic              exc_ri;
  } entry_t;

  dec_t        dec;
  entry_t      new_e;
  entry_t      main_q, main_d;
  entry_t      skid_q, skid_d;
  logic        main_vld_q, main_vld_d;
  logic        skid_vld_q, skid_vld_d;
  logic        rdy_q, rdy_d;
  logic        acc;
  logic        drain;
  logic [31:0] target32;

  id_decode u_decode (
    .inst_code (in_inst_code),
    .dec       (dec)
  );

  // Target nibble comes from pc+4 with 32-bit wraparound; result sign-extends to DATA_W.
  always_comb begin : build_entry
    target32          = {4'((32'(in_pc) + 32'd4) >> 28), in_inst_code[25:0], 2'b00};
    new_e             = '0;
    new_e.pc          = in_pc;
    new_e.inst        = dec.inst;
    new_e.itype       = dec.itype;
    new_e.reg_s       = dec.rs;
    new_e.reg_t       = dec.rt;
    new_e.shift       = dec.shamt;
    new_e.exc_ri      = (dec.itype == INST_TYPE_INVALID);
    case (dec.ext_mode)
      EXT_ZERO:  new_e.imm = DATA_W'(dec.imm16);
      EXT_UPPER: new_e.imm = DATA_W'($signed({dec.imm16, 16'h0000}));
      default:   new_e.imm = DATA_W'($signed(dec.imm16));
    endcase
    if (dec.itype == INST_TYPE_J) new_e.jump_target = DATA_W'($signed(target32));
    case (dec.itype)
      INST_TYPE_R: new_e.reg_d = dec.rd;
      INST_TYPE_I: new_e.reg_d = dec.rt;
      INST_TYPE_J: new_e.reg_d = (dec.inst == INST_JAL) ? 5'(LINK_REG) : 5'd0;
      default:     new_e.reg_d = 5'd0;
    endcase
  end

  assign acc   = in_valid & in_ready;
  assign drain = main_vld_q & out_ready;

  // Flush wins; a draining main refills from skid first, else from the input.
  always_comb begin : next_state
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || drain) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (acc) begin
        main_d     = new_e;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (acc && SKID_EN) begin
      skid_d     = new_e;
      skid_vld_d = 1'b1;
    end
    rdy_d = SKID_EN ? !skid_vld_d : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
    end
  end

  assign in_ready        = SKID_EN ? rdy_q : (rdy_q & (~main_vld_q | out_ready));
  assign out_valid       = main_vld_q;
  assign out_pc          = main_q.pc;
  assign out_inst        = main_q.inst;
  assign out_type        = main_q.itype;
  assign out_reg_s       = main_q.reg_s;
  assign out_reg_t       = main_q.reg_t;
  assign out_reg_d       = main_q.reg_d;
  assign out_imm         = main_q.imm;
  assign out_shift       = main_q.shift;
  assign out_jump_target = main_q.jump_target;
  assign out_exc_ri      = main_q.exc_ri;

endmodule

// File: tb/tb_id_pipe.sv
// Directed self-checking bench for id_pipe: decode fields, handshake,
// backpressure through the skid buffer, flush and asynchronous reset.
module tb_id_pipe;

  localparam logic [7:0] E_INVALID = 8'd0;
  localparam logic [7:0] E_ADDU    = 8'd2;
  localparam logic [7:0] E_SLL     = 8'd11;
  localparam logic [7:0] E_ADDIU   = 8'd16;
  localparam logic [7:0] E_ORI     = 8'd20;
  localparam logic [7:0] E_LUI     = 8'd22;
  localparam logic [7:0] E_J       = 8'd29;
  localparam logic [7:0] E_JAL     = 8'd30;
  localparam logic [1:0] T_INV = 2'd0, T_R = 2'd1, T_I = 2'd2, T_J = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst_code = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [7:0]  out_inst;
  logic [1:0]  out_type;
  logic [4:0]  out_reg_s, out_reg_t, out_reg_d, out_shift;
  logic [31:0] out_imm, out_jump_target;
  logic        out_exc_ri;

  int checks = 0;
  int failures = 0;

  id_pipe #(.DATA_W(32), .SKID_EN(1'b1), .LINK_REG(31)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_pc           (in_pc),
    .in_inst_code    (in_inst_code),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .out_type        (out_type),
    .out_reg_s       (out_reg_s),
    .out_reg_t       (out_reg_t),
    .out_reg_d       (out_reg_d),
    .out_imm         (out_imm),
    .out_shift       (out_shift),
    .out_jump_target (out_jump_target),
    .out_exc_ri      (out_exc_ri)
  );

  always #5 clk = ~clk;

  // Offer one instruction for one edge; returns at the following negedge.
  task automatic send(input logic [31:0] pc, input logic [31:0] code);
    in_valid     = 1'b1;
    in_pc        = pc;
    in_inst_code = code;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0h exp=0", in_ready); end
    checks++;
    if ({out_pc, out_imm, out_jump_target, out_inst, out_type, out_reg_s, out_reg_t, out_reg_d, out_shift, out_exc_ri} !== '0) begin
      failures++; $display("FAIL reset_data got pc=%0h imm=%0h tgt=%0h inst=%0h exp=all_zero", out_pc, out_imm, out_jump_target, out_inst);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_before_edge got=%0h exp=0", in_ready); end
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after_edge got=%0h exp=1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_decode_i();
    out_ready = 1'b1;
    send(32'h8000_0000, 32'h2509_FFFF);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL addiu_valid got=%0h exp=1", out_valid); end
    checks++; if (out_pc !== 32'h8000_0000) begin failures++; $display("FAIL addiu_pc got=%0h exp=80000000", out_pc); end
    checks++; if ({out_inst, out_type} !== {E_ADDIU, T_I}) begin failures++; $display("FAIL addiu_inst_type got=%0h/%0h exp=%0h/%0h", out_inst, out_type, E_ADDIU, T_I); end
    checks++; if ({out_reg_s, out_reg_t, out_reg_d} !== {5'd8, 5'd9, 5'd9}) begin failures++; $display("FAIL addiu_regs got=%0d/%0d/%0d exp=8/9/9", out_reg_s, out_reg_t, out_reg_d); end
    checks++; if (out_imm !== 32'hFFFF_FFFF) begin failures++; $display("FAIL addiu_imm got=%0h exp=ffffffff", out_imm); end
    checks++; if ({out_exc_ri, out_shift, out_jump_target} !== '0) begin failures++; $display("FAIL addiu_zero_fields got=%0h/%0h/%0h exp=0", out_exc_ri, out_shift, out_jump_target); end
    send(32'h8000_0004, 32'h3509_FFFF);
    checks++; if ({out_inst, out_type} !== {E_ORI, T_I}) begin failures++; $display("FAIL ori_inst_type got=%0h/%0h exp=%0h/%0h", out_inst, out_type, E_ORI, T_I); end
    checks++; if (out_imm !== 32'h0000_FFFF) begin failures++; $display("FAIL ori_imm got=%0h exp=0000ffff", out_imm); end
    send(32'h8000_0008, 32'h3C01_1234);
    checks++; if (out_inst !== E_LUI) begin failures++; $display("FAIL lui_inst got=%0h exp=%0h", out_inst, E_LUI); end
    checks++; if (out_imm !== 32'h1234_0000) begin failures++; $display("FAIL lui_imm got=%0h exp=12340000", out_imm); end
    checks++; if ({out_reg_s, out_reg_t, out_reg_d} !== {5'd0, 5'd1, 5'd1}) begin failures++; $display("FAIL lui_regs got=%0d/%0d/%0d exp=0/1/1", out_reg_s, out_reg_t, out_reg_d); end
    idle_cycle();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL decode_i_drained got=%0h exp=0", out_valid); end
  endtask

  task automatic test_decode_rj();
    out_ready = 1'b1;
    send(32'h0000_0100, 32'h0109_5021);
    checks++; if ({out_inst, out_type} !== {E_ADDU, T_R}) begin failures++; $display("FAIL addu_inst_type got=%0h/%0h exp=%0h/%0h", out_inst, out_type, E_ADDU, T_R); end
    checks++; if ({out_reg_s, out_reg_t, out_reg_d, out_shift} !== {5'd8, 5'd9, 5'd10, 5'd0}) begin failures++; $display("FAIL addu_regs got=%0d/%0d/%0d/%0d exp=8/9/10/0", out_reg_s, out_reg_t, out_reg_d, out_shift); end
    checks++; if (out_imm !== 32'h0) begin failures++; $display("FAIL addu_imm got=%0h exp=0", out_imm); end
    send(32'h0000_0104, 32'h0009_4080);
    checks++; if (out_inst !== E_SLL) begin failures++; $display("FAIL sll_inst got=%0h exp=%0h", out_inst, E_SLL); end
    checks++; if ({out_reg_s, out_reg_t, out_reg_d, out_shift} !== {5'd0, 5'd9, 5'd8, 5'd2}) begin failures++; $display("FAIL sll_fields got=%0d/%0d/%0d/%0d exp=0/9/8/2", out_reg_s, out_reg_t, out_reg_d, out_shift); end
    send(32'h8000_0000, 32'h0C00_0010);
    checks++; if ({out_inst, out_type} !== {E_JAL, T_J}) begin failures++; $display("FAIL jal_inst_type got=%0h/%0h exp=%0h/%0h", out_inst, out_type, E_JAL, T_J); end
    checks++; if (out_reg_d !== 5'd31) begin failures++; $display("FAIL jal_reg_d got=%0d exp=31", out_reg_d); end
    checks++; if (out_jump_target !== 32'h8000_0040) begin failures++; $display("FAIL jal_target got=%0h exp=80000040", out_jump_target); end
    checks++; if ({out_imm, out_reg_s, out_reg_t} !== '0) begin failures++; $display("FAIL jal_zero_fields got=%0h/%0d/%0d exp=0", out_imm, out_reg_s, out_reg_t); end
    send(32'hFFFF_FFFC, 32'h0800_0010);
    checks++; if (out_inst !== E_J) begin failures++; $display("FAIL j_inst got=%0h exp=%0h", out_inst, E_J); end
    checks++; if (out_jump_target !== 32'h0000_0040) begin failures++; $display("FAIL j_wrap_target got=%0h exp=00000040", out_jump_target); end
    checks++; if (out_reg_d !== 5'd0) begin failures++; $display("FAIL j_reg_d got=%0d exp=0", out_reg_d); end
    idle_cycle();
  endtask

  task automatic test_invalid();
    out_ready = 1'b1;
    send(32'h0000_0200, 32'hFC00_0000);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL inv_valid got=%0h exp=1", out_valid); end
    checks++; if ({out_inst, out_type, out_exc_ri} !== {E_INVALID, T_INV, 1'b1}) begin failures++; $display("FAIL inv_marks got=%0h/%0h/%0h exp=0/0/1", out_inst, out_type, out_exc_ri); end
    checks++; if (out_pc !== 32'h0000_0200) begin failures++; $display("FAIL inv_pc got=%0h exp=200", out_pc); end
    send(32'h0000_0204, 32'hFFFF_FFFF);
    checks++; if ({out_type, out_exc_ri} !== {T_INV, 1'b1}) begin failures++; $display("FAIL inv_ones_type got=%0h/%0h exp=0/1", out_type, out_exc_ri); end
    checks++;
    if ({out_reg_s, out_reg_t, out_reg_d, out_imm, out_shift, out_jump_target} !== '0) begin
      failures++; $display("FAIL inv_ones_fields got=%0d/%0d/%0d/%0h/%0d/%0h exp=0", out_reg_s, out_reg_t, out_reg_d, out_imm, out_shift, out_jump_target);
    end
    send(32'h0000_0208, 32'h0000_003F);
    checks++; if ({out_type, out_exc_ri} !== {T_INV, 1'b1}) begin failures++; $display("FAIL inv_funct got=%0h/%0h exp=0/1", out_type, out_exc_ri); end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid     = 1'b1;
      in_pc        = 32'h300 + 32'(4 * k);
      in_inst_code = 32'h2409_0000 | 32'(k);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready k=%0d got=%0h exp=1", k, in_ready); end
      @(posedge clk);
      @(negedge clk);
      checks++; if ({out_valid, out_pc, out_imm} !== {1'b1, 32'h300 + 32'(4 * k), 32'(k)}) begin
        failures++; $display("FAIL b2b_out k=%0d got=%0h/%0h/%0h exp=1/%0h/%0h", k, out_valid, out_pc, out_imm, 32'h300 + 32'(4 * k), k);
      end
    end
    in_valid = 1'b0;
    idle_cycle();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%0h exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] pcs [4];
    int sent, recv, drop_at;
    bit acc, drn;
    sent = 0; recv = 0; drop_at = -1;
    for (int i = 0; i < 4; i++) pcs[i] = 32'h400 + 32'(4 * i);
    for (int cyc = 0; cyc < 30 && recv < 4; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid  = (sent < 4);
      if (sent < 4) begin
        in_pc        = pcs[sent];
        in_inst_code = 32'h2409_0000 | 32'(sent);
      end
      #1;
      if (!in_ready && drop_at < 0) drop_at = sent;
      acc = in_valid && in_ready;
      drn = out_valid && out_ready;
      if (out_valid) begin
        checks++; if ({out_pc, out_imm} !== {pcs[recv], 32'(recv)}) begin
          failures++; $display("FAIL bp_order cyc=%0d got=%0h/%0h exp=%0h/%0h", cyc, out_pc, out_imm, pcs[recv], recv);
        end
      end
      if (drn) recv++;
      if (acc) sent++;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (recv != 4) begin failures++; $display("FAIL bp_all_out got=%0d exp=4", recv); end
    checks++; if (drop_at != 2) begin failures++; $display("FAIL bp_ready_drop got=%0d exp=2", drop_at); end
    idle_cycle();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(32'h0000_0500, 32'h2409_0005);
    send(32'h0000_0504, 32'h2409_0006);
    checks++; if ({in_ready, out_valid} !== 2'b01) begin failures++; $display("FAIL flush_full got=%0h/%0h exp=0/1", in_ready, out_valid); end
    in_valid = 1'b1; in_pc = 32'h0000_0508; in_inst_code = 32'h2409_0007; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0h exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%0h exp=1", in_ready); end
    idle_cycle();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_ghost got=%0h exp=0", out_valid); end
    in_valid = 1'b1; in_pc = 32'h0000_050C; in_inst_code = 32'h2409_0008; flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready_unaffected got=%0h exp=1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_drop_hs got=%0h exp=0", out_valid); end
    out_ready = 1'b1;
    send(32'h0000_0510, 32'h3509_FFFF);
    checks++; if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h0000_0510, E_ORI}) begin
      failures++; $display("FAIL flush_resume got=%0h/%0h/%0h exp=1/510/%0h", out_valid, out_pc, out_inst, E_ORI);
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(32'h0000_0600, 32'h2409_0009);
    send(32'h0000_0604, 32'h2409_000A);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL async_rst_valid got=%0h exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL async_rst_ready got=%0h exp=0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();
    checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL rst_restart got=%0h/%0h exp=1/0", in_ready, out_valid); end
    out_ready = 1'b1;
    send(32'h0000_0608, 32'h0C00_0010);
    checks++; if ({out_valid, out_pc, out_reg_d} !== {1'b1, 32'h0000_0608, 5'd31}) begin
      failures++; $display("FAIL rst_resume got=%0h/%0h/%0d exp=1/608/31", out_valid, out_pc, out_reg_d);
    end
    checks++; if (out_jump_target !== 32'h0000_0040) begin failures++; $display("FAIL rst_resume_target got=%0h exp=00000040", out_jump_target); end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_decode_i();
    test_decode_rj();
    test_invalid();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
